cdd_sector_streamer: RTL and testbench
======================================

CDD_SECTOR_STREAMER -- requirements
Module: cdd_sector_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, input word buffer depth (power of two, 4..64).
REQ-002 SHALL have CLK  in  1  system clock; all logic rising-edge; one clock, synchronous active-high reset.
REQ-003 SHALL have RST  in  1  synchronous active-high reset.
REQ-004 SHALL have WORD_CE  in  1  one-cycle strobe at 176400 Hz, the 2x word slot.
REQ-005 SHALL have CD_SPD  in  1  1 = 2x speed (every WORD_CE), 0 = 1x (every second WORD_CE).
REQ-006 SHALL have RUN  in  1  level: stream sectors while high.
REQ-007 SHALL have AUDIO  in  1  1 = CDDA sector, sync-pattern check disabled.
REQ-008 SHALL have HOST_DATA  in  16  sector word, low byte = earlier disc byte.
REQ-009 SHALL have HOST_SOF  in  1  qualifies HOST_DATA as word 0 of a sector.
REQ-010 SHALL have HOST_VALID  in  1  and HOST_READY  out  1  valid/ready handshake; a word transfers when both are high.
REQ-011 SHALL have CD_D  out  16  word to the CD interface FIFO.
REQ-012 SHALL have CD_CK  out  1  word strobe; the consumer captures on its rising edge.
REQ-013 SHALL have SECTOR_DONE  out  1  one-cycle pulse after word 1175 is emitted.
REQ-014 SHALL have STATUS  out  3  sticky {ALIGN_ERR, SYNC_ERR, UNDERRUN}.
REQ-015 SHALL have UNDERRUN_CNT  out  8  saturating underrun count (see Configuration).

Function
REQ-016 Sector length SHALL be 1176 words (2352 bytes); output word counter WCNT SHALL run 0..1175 and wrap to 0.
REQ-017 FIFO entries SHALL be 17 bits {SOF, DATA}; HOST_READY = not full; push on HOST_VALID & HOST_READY.
REQ-018 Output slot SHALL be WORD_CE & (CD_SPD | DIV), with DIV toggling on every WORD_CE and cleared by reset.
REQ-019 States SHALL be IDLE, PRIME, STREAM, DRAIN.
REQ-020 IDLE: CD_CK=0; if RUN=1, go to PRIME.
REQ-021 PRIME: discard non-SOF FIFO heads at one per cycle; go to STREAM when the head has SOF=1; RUN=0 returns to IDLE.
REQ-022 STREAM, per slot with FIFO non-empty: pop, CD_D<=DATA, CD_CK high for exactly 4 CLK cycles from the next cycle, WCNT advances.
REQ-023 CD_D SHALL remain stable from its update until the next slot's update.
REQ-024 Slot with FIFO empty in STREAM: emit 16'h0000 with CD_CK pulse, advance WCNT, set UNDERRUN.
REQ-025 Popped SOF=1 with WCNT != 0: set ALIGN_ERR, force WCNT=0 for that word.
REQ-026 Popped SOF=0 with WCNT = 0: set ALIGN_ERR; the word is still emitted.
REQ-027 AUDIO=0: words 0..5 SHALL be compared to FF00, FFFF, FFFF, FFFF, FFFF, 00FF; any mismatch sets SYNC_ERR; the sector still streams.
REQ-028 After word 1175: pulse SECTOR_DONE; RUN=0 then enters DRAIN, else STREAM continues.
REQ-029 DRAIN: wait until the CD_CK pulse ends, then go to IDLE; FIFO contents are retained.
REQ-030 Simultaneous push and pop on a full FIFO: pop frees space before the push; HOST_READY SHALL reflect the pre-pop state (no combinational path from pop to READY).
REQ-031 STATUS bits SHALL clear only on reset.
REQ-032 Slot while a previous CD_CK pulse is still high: impossible by rate; the new pulse SHALL restart the 4-cycle count.

Reset
REQ-033 Reset values: CD_D=0, CD_CK=0, SECTOR_DONE=0, STATUS=0, UNDERRUN_CNT=0, HOST_READY=0 during reset, FIFO empty, WCNT=0, state IDLE, DIV=0.
REQ-034 Reset mid-sector SHALL abort immediately; the next sector starts at PRIME.

Configuration
REQ-035 With macro CDD_STREAM_ERRCNT_EN defined, UNDERRUN_CNT SHALL increment once per underrun slot and saturate at 8'hFF.
REQ-036 Without the macro, UNDERRUN_CNT SHALL be constant 0 and no counter logic is built; UNDERRUN still functions.

Verification
REQ-037 RUN=1, CD_SPD=1, AUDIO=0, one valid data sector pre-filled -> 1176 CD_CK rising edges, one per WORD_CE; SECTOR_DONE once; STATUS=000.
REQ-038 Same stimulus with CD_SPD=0 -> word spacing = 2 WORD_CE periods; sector duration 1/75 s +/-1 slot.
REQ-039 HOST_VALID dropped for words 100..109 with FIFO drained -> ten 16'h0000 words emitted; UNDERRUN=1; UNDERRUN_CNT=10 with macro, 0 without.
REQ-040 Word 3 = 16'h1234, AUDIO=0 -> SYNC_ERR=1; same with AUDIO=1 -> SYNC_ERR=0.
REQ-041 SOF injected at word 500 -> ALIGN_ERR=1; that word emitted with WCNT=0; the following sector aligns normally.
REQ-042 RST pulsed at word 600 -> all outputs return to reset values next cycle; a subsequent RUN=1 skips non-SOF words until the next SOF.

Source files
------------

// File: rtl/cdd_sector_streamer.sv
// cdd_sector_streamer: buffers 16-bit host sector words in a small FIFO and
// replays them to the CD interface at the 1x/2x word rate. Each word is
// presented on CD_D with a 4-cycle CD_CK strobe. The block also tracks sector
// alignment and checks the data-sector sync pattern.
// Optional feature: define CDD_STREAM_ERRCNT_EN to build the saturating
// underrun counter behind UNDERRUN_CNT. When it is undefined, UNDERRUN_CNT
// is tied to zero.
module cdd_sector_streamer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WORD_CE,
  input  logic        CD_SPD,
  input  logic        RUN,
  input  logic        AUDIO,
  input  logic [15:0] HOST_DATA,
  input  logic        HOST_SOF,
  input  logic        HOST_VALID,
  output logic        HOST_READY,
  output logic [15:0] CD_D,
  output logic        CD_CK,
  output logic        SECTOR_DONE,
  output logic [2:0]  STATUS,
  output logic [7:0]  UNDERRUN_CNT
);

  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [10:0]   LAST_WORD = 11'd1175;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Expected sync pattern for the first six words of a data sector.
  function automatic logic [15:0] sync_word(input logic [2:0] idx);
    case (idx)
      3'd0:    sync_word = 16'hFF00;
      3'd1:    sync_word = 16'hFFFF;
      3'd2:    sync_word = 16'hFFFF;
      3'd3:    sync_word = 16'hFFFF;
      3'd4:    sync_word = 16'hFFFF;
      3'd5:    sync_word = 16'h00FF;
      default: sync_word = 16'h0000;
    endcase
  endfunction

  logic [16:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r, count_nxt_s;
  logic          ready_r;
  logic          div_r;
  state_t        state_r;
  logic [10:0]   wcnt_r, eff_wcnt_s;
  logic [15:0]   cd_d_r, out_word_s;
  logic          cd_ck_r;
  logic [1:0]    ck_rem_r;
  logic          done_r;
  logic [2:0]    status_r;
  logic          empty_s, slot_s, push_s, pop_s, align_err_s, sync_err_s;
  logic [16:0]   head_s;

  // FIFO control, output slot, and per-word error decode.
  always_comb begin
    empty_s = (count_r == {(AW+1){1'b0}});
    head_s  = mem_r[rd_ptr_r];
    slot_s  = WORD_CE & (CD_SPD | div_r);
    push_s  = HOST_VALID & ready_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_PRIME:  pop_s = RUN & ~empty_s & ~head_s[16];
      ST_STREAM: pop_s = slot_s & ~empty_s;
      default:   pop_s = 1'b0;
    endcase
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    // A SOF word always lands at word 0, even when it arrives early.
    eff_wcnt_s  = (~empty_s & head_s[16]) ? 11'd0 : wcnt_r;
    out_word_s  = empty_s ? 16'h0000 : head_s[15:0];
    align_err_s = ~empty_s & (head_s[16] ? (wcnt_r != 11'd0) : (wcnt_r == 11'd0));
    sync_err_s  = ~AUDIO & (eff_wcnt_s < 11'd6) & (out_word_s != sync_word(eff_wcnt_s[2:0]));
  end

  // FIFO storage write port (data path, no reset needed).
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {HOST_SOF, HOST_DATA};
    end
  end

  // FIFO pointers, occupancy, and registered ready (computed from next occupancy).
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != DEPTH_C);
    end
  end

  // 1x rate divider: toggles on every word strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_r <= 1'b0;
    end else if (WORD_CE) begin
      div_r <= ~div_r;
    end
  end

  // Sequencer: priming, word emission, strobe timing, and sticky status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      wcnt_r   <= 11'd0;
      cd_d_r   <= 16'h0000;
      cd_ck_r  <= 1'b0;
      ck_rem_r <= 2'd0;
      done_r   <= 1'b0;
      status_r <= 3'b000;
    end else begin
      done_r <= 1'b0;
      if (cd_ck_r) begin
        if (ck_rem_r == 2'd0) cd_ck_r <= 1'b0;
        else                  ck_rem_r <= ck_rem_r - 2'd1;
      end
      case (state_r)
        ST_IDLE: begin
          cd_ck_r <= 1'b0;
          if (RUN) state_r <= ST_PRIME;
        end
        ST_PRIME: begin
          if (!RUN)                       state_r <= ST_IDLE;
          else if (!empty_s && head_s[16]) state_r <= ST_STREAM;
        end
        ST_STREAM: begin
          if (slot_s) begin
            cd_d_r      <= out_word_s;
            cd_ck_r     <= 1'b1;
            ck_rem_r    <= 2'd3;
            status_r[2] <= status_r[2] | align_err_s;
            status_r[1] <= status_r[1] | sync_err_s;
            status_r[0] <= status_r[0] | empty_s;
            if (eff_wcnt_s == LAST_WORD) begin
              wcnt_r <= 11'd0;
              done_r <= 1'b1;
              if (!RUN) state_r <= ST_DRAIN;
            end else begin
              wcnt_r <= eff_wcnt_s + 11'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (!cd_ck_r) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef CDD_STREAM_ERRCNT_EN
  logic [7:0] urun_cnt_r;

  // Saturating count of slots that found the FIFO empty while streaming.
  always_ff @(posedge CLK) begin
    if (RST) begin
      urun_cnt_r <= 8'h00;
    end else if ((state_r == ST_STREAM) && slot_s && empty_s && (urun_cnt_r != 8'hFF)) begin
      urun_cnt_r <= urun_cnt_r + 8'h01;
    end
  end

  assign UNDERRUN_CNT = urun_cnt_r;
`else
  assign UNDERRUN_CNT = 8'h00;
`endif

  assign HOST_READY  = ready_r;
  assign CD_D        = cd_d_r;
  assign CD_CK       = cd_ck_r;
  assign SECTOR_DONE = done_r;
  assign STATUS      = status_r;

endmodule

// File: tb/tb_cdd_sector_streamer.sv
// Testbench for cdd_sector_streamer: random sector payloads are checked
// against a word-list reference model of sector alignment and status rules.
module tb_cdd_sector_streamer;

  logic        CLK = 1'b0;
  logic        RST, WORD_CE, CD_SPD, RUN, AUDIO;
  logic [15:0] HOST_DATA;
  logic        HOST_SOF, HOST_VALID, HOST_READY;
  logic [15:0] CD_D;
  logic        CD_CK, SECTOR_DONE;
  logic [2:0]  STATUS;
  logic [7:0]  UNDERRUN_CNT;

  cdd_sector_streamer #(.FIFO_DEPTH(16)) dut (
    .CLK(CLK), .RST(RST), .WORD_CE(WORD_CE), .CD_SPD(CD_SPD), .RUN(RUN),
    .AUDIO(AUDIO), .HOST_DATA(HOST_DATA), .HOST_SOF(HOST_SOF),
    .HOST_VALID(HOST_VALID), .HOST_READY(HOST_READY), .CD_D(CD_D),
    .CD_CK(CD_CK), .SECTOR_DONE(SECTOR_DONE), .STATUS(STATUS),
    .UNDERRUN_CNT(UNDERRUN_CNT)
  );

  initial forever #5 CLK = ~CLK;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Word strobe every 8 clocks (scaled-down 176.4 kHz slot).
  initial begin
    WORD_CE = 1'b0;
    forever begin
      repeat (7) @(posedge CLK);
      #1 WORD_CE = 1'b1;
      @(posedge CLK);
      #1 WORD_CE = 1'b0;
    end
  end

  // Host side: streams host_q through the valid/ready handshake.
  logic [16:0] host_q[$];
  bit          will_xfer;
  initial begin
    HOST_VALID = 1'b0; HOST_DATA = 16'h0000; HOST_SOF = 1'b0;
    forever begin
      @(negedge CLK);
      will_xfer = HOST_VALID && HOST_READY;
      @(posedge CLK);
      #1;
      if (will_xfer && host_q.size() > 0) void'(host_q.pop_front());
      if (host_q.size() > 0) begin
        HOST_VALID = 1'b1;
        {HOST_SOF, HOST_DATA} = host_q[0];
      end else begin
        HOST_VALID = 1'b0;
      end
    end
  end

  // Consumer side: records every word at CD_CK rising, strobe widths, done pulses.
  logic [15:0] mon_q[$];
  int          mon_t[$];
  int          width_err = 0;
  int          done_cnt  = 0;
  int          done_at   = 0;
  int          hi_len    = 0;
  logic        prev_ck   = 1'b0;
  always @(negedge CLK) begin
    if (CD_CK && !prev_ck) begin
      mon_q.push_back(CD_D);
      mon_t.push_back(cyc);
    end
    if (CD_CK) hi_len = hi_len + 1;
    else begin
      if (prev_ck && hi_len != 4) width_err = width_err + 1;
      hi_len = 0;
    end
    if (SECTOR_DONE) begin
      done_cnt = done_cnt + 1;
      done_at  = mon_q.size();
    end
    prev_ck = CD_CK;
  end

  // Reference data: exp_q holds {underrun, sof, data} in expected emission order.
  logic [17:0] exp_q[$];
  logic [16:0] sec_q[$];

  function automatic logic [15:0] hdr_word(input int i);
    case (i)
      0:       return 16'hFF00;
      1, 2, 3, 4: return 16'hFFFF;
      5:       return 16'h00FF;
      default: return 16'h0000;
    endcase
  endfunction

  // Builds one 1176-word sector with a valid header, word 3 replaced by w3.
  task automatic build_sector(input logic [15:0] w3);
    logic [15:0] d;
    sec_q.delete();
    for (int i = 0; i < 1176; i++) begin
      d = (i < 6) ? hdr_word(i) : 16'($urandom);
      if (i == 3) d = w3;
      sec_q.push_back({(i == 0), d});
    end
  endtask

  // Walks the expected stream with the sector rules and predicts STATUS and SECTOR_DONE count.
  function automatic void ref_model(input bit audio, output logic [2:0] st, output int dones);
    int w;
    logic ur, sof;
    logic [15:0] d;
    w = 0; st = 3'b000; dones = 0;
    foreach (exp_q[i]) begin
      ur = exp_q[i][17]; sof = exp_q[i][16]; d = exp_q[i][15:0];
      if (ur) st[0] = 1'b1;
      else if (sof && w != 0) begin st[2] = 1'b1; w = 0; end
      else if (!sof && w == 0) st[2] = 1'b1;
      if (!audio && w < 6 && d != hdr_word(w)) st[1] = 1'b1;
      if (w == 1175) begin dones++; w = 0; end
      else w++;
    end
  endfunction

  function automatic int first_diff(input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= mon_q.size()) return i;
      if (mon_q[base + i] !== exp_q[i][15:0]) return i;
    end
    return -1;
  endfunction

  function automatic int spacing_bad(input int base, input int n, input int sp);
    int b = 0;
    for (int i = 1; i < n && base + i < mon_t.size(); i++)
      if (mon_t[base + i] - mon_t[base + i - 1] != sp) b++;
    return b;
  endfunction

  task automatic wait_words(input int base, input int n, input int budget, input string tag);
    int k = 0;
    while ((mon_q.size() - base) < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if ((mon_q.size() - base) < n) begin
      n_chk++;
      $display("FAIL %s_timeout: got %0d words, required %0d", tag, mon_q.size() - base, n);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; RUN = 1'b0;
    host_q.delete();
    repeat (4) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; RUN = 1'b0; CD_SPD = 1'b1; AUDIO = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_chk++; if (CD_D !== 16'h0000) $display("FAIL rst_cd_d: got %h required 0000", CD_D); else n_pass++;
    n_chk++; if (CD_CK !== 1'b0) $display("FAIL rst_cd_ck: got %b required 0", CD_CK); else n_pass++;
    n_chk++; if (SECTOR_DONE !== 1'b0) $display("FAIL rst_done: got %b required 0", SECTOR_DONE); else n_pass++;
    n_chk++; if (STATUS !== 3'b000) $display("FAIL rst_status: got %b required 000", STATUS); else n_pass++;
    n_chk++; if (UNDERRUN_CNT !== 8'h00) $display("FAIL rst_ucnt: got %h required 00", UNDERRUN_CNT); else n_pass++;
    n_chk++; if (HOST_READY !== 1'b0) $display("FAIL rst_ready: got %b required 0", HOST_READY); else n_pass++;
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_sector_speed(input bit spd);
    int base, wb, d, sb, dones, dc0;
    logic [2:0] st_e;
    string tag;
    tag = spd ? "sec2x" : "sec1x";
    do_reset();
    build_sector(16'hFFFF);
    exp_q.delete();
    foreach (sec_q[i]) begin host_q.push_back(sec_q[i]); exp_q.push_back({1'b0, sec_q[i]}); end
    CD_SPD = spd; AUDIO = 1'b0;
    repeat (30) @(posedge CLK);
    base = mon_q.size(); wb = width_err; dc0 = done_cnt;
    #1 RUN = 1'b1;
    wait_words(base, 10, 2000, tag);
    RUN = 1'b0;
    wait_words(base, 1176, spd ? 10000 : 19500, tag);
    repeat (60) @(negedge CLK);
    ref_model(1'b0, st_e, dones);
    n_chk++; if (mon_q.size() - base != 1176) $display("FAIL %s_count: got %0d required 1176", tag, mon_q.size() - base); else n_pass++;
    d = first_diff(base);
    n_chk++; if (d !== -1) $display("FAIL %s_words: first bad index %0d", tag, d); else n_pass++;
    n_chk++; if (STATUS !== st_e) $display("FAIL %s_status: got %b required %b", tag, STATUS, st_e); else n_pass++;
    n_chk++; if (done_cnt - dc0 != dones) $display("FAIL %s_done: got %0d required %0d", tag, done_cnt - dc0, dones); else n_pass++;
    sb = spacing_bad(base, 1176, spd ? 8 : 16);
    n_chk++; if (sb != 0) $display("FAIL %s_spacing: got %0d bad gaps required 0", tag, sb); else n_pass++;
    n_chk++; if (width_err - wb != 0) $display("FAIL %s_width: got %0d bad strobes required 0", tag, width_err - wb); else n_pass++;
    if (!spd && mon_t.size() >= base + 1176) begin
      n_chk++;
      if (mon_t[base + 1175] - mon_t[base] != 1175 * 16)
        $display("FAIL sec1x_span: got %0d cycles required %0d", mon_t[base + 1175] - mon_t[base], 1175 * 16);
      else n_pass++;
    end
  endtask

  task automatic test_underrun();
    int base, d, dones, dc0, zbad;
    logic [2:0] st_e;
    logic [7:0] ucnt_e;
`ifdef CDD_STREAM_ERRCNT_EN
    ucnt_e = 8'd10;
`else
    ucnt_e = 8'd0;
`endif
    do_reset();
    build_sector(16'hFFFF);
    exp_q.delete();
    for (int i = 0; i < 100; i++) begin host_q.push_back(sec_q[i]); exp_q.push_back({1'b0, sec_q[i]}); end
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b1, 1'b0, 16'h0000});
    for (int i = 100; i < 1166; i++) exp_q.push_back({1'b0, sec_q[i]});
    CD_SPD = 1'b1; AUDIO = 1'b0;
    repeat (30) @(posedge CLK);
    base = mon_q.size(); dc0 = done_cnt;
    #1 RUN = 1'b1;
    wait_words(base, 110, 2000, "urun");
    for (int i = 100; i < 1166; i++) host_q.push_back(sec_q[i]);
    RUN = 1'b0;
    wait_words(base, 1176, 10000, "urun");
    repeat (60) @(negedge CLK);
    ref_model(1'b0, st_e, dones);
    n_chk++; if (mon_q.size() - base != 1176) $display("FAIL urun_count: got %0d required 1176", mon_q.size() - base); else n_pass++;
    zbad = 0;
    for (int i = 100; i < 110 && base + i < mon_q.size(); i++) if (mon_q[base + i] !== 16'h0000) zbad++;
    n_chk++; if (zbad != 0) $display("FAIL urun_zeros: got %0d nonzero filler words required 0", zbad); else n_pass++;
    d = first_diff(base);
    n_chk++; if (d !== -1) $display("FAIL urun_words: first bad index %0d", d); else n_pass++;
    n_chk++; if (STATUS !== st_e) $display("FAIL urun_status: got %b required %b", STATUS, st_e); else n_pass++;
    n_chk++; if (UNDERRUN_CNT !== ucnt_e) $display("FAIL urun_cnt: got %0d required %0d", UNDERRUN_CNT, ucnt_e); else n_pass++;
    n_chk++; if (done_cnt - dc0 != dones) $display("FAIL urun_done: got %0d required %0d", done_cnt - dc0, dones); else n_pass++;
  endtask

  task automatic test_sync();
    int base, dones;
    logic [2:0] st_e;
    for (int a = 0; a < 2; a++) begin
      do_reset();
      build_sector(16'h1234);
      exp_q.delete();
      foreach (sec_q[i]) host_q.push_back(sec_q[i]);
      for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, sec_q[i]});
      CD_SPD = 1'b1; AUDIO = a[0];
      repeat (20) @(posedge CLK);
      base = mon_q.size();
      #1 RUN = 1'b1;
      wait_words(base, 20, 2000, "sync");
      ref_model(a[0], st_e, dones);
      n_chk++;
      if (STATUS !== st_e) $display("FAIL sync_audio%0d_status: got %b required %b", a, STATUS, st_e);
      else n_pass++;
    end
  endtask

  task automatic test_align();
    int base, d, dones, dc0;
    logic [2:0] st_e;
    do_reset();
    exp_q.delete();
    build_sector(16'hFFFF);
    for (int i = 0; i < 500; i++) begin host_q.push_back(sec_q[i]); exp_q.push_back({1'b0, sec_q[i]}); end
    build_sector(16'hFFFF);
    foreach (sec_q[i]) begin host_q.push_back(sec_q[i]); exp_q.push_back({1'b0, sec_q[i]}); end
    CD_SPD = 1'b1; AUDIO = 1'b0;
    repeat (30) @(posedge CLK);
    base = mon_q.size(); dc0 = done_cnt;
    #1 RUN = 1'b1;
    wait_words(base, 30, 2000, "align");
    RUN = 1'b0;
    wait_words(base, 1676, 14000, "align");
    repeat (60) @(negedge CLK);
    ref_model(1'b0, st_e, dones);
    n_chk++; if (mon_q.size() - base != 1676) $display("FAIL align_count: got %0d required 1676", mon_q.size() - base); else n_pass++;
    d = first_diff(base);
    n_chk++; if (d !== -1) $display("FAIL align_words: first bad index %0d", d); else n_pass++;
    n_chk++; if (STATUS !== st_e) $display("FAIL align_status: got %b required %b", STATUS, st_e); else n_pass++;
    n_chk++; if (done_cnt - dc0 != dones) $display("FAIL align_done: got %0d required %0d", done_cnt - dc0, dones); else n_pass++;
    n_chk++; if (done_at - base != 1676) $display("FAIL align_done_pos: got word %0d required 1676", done_at - base); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base, d;
    do_reset();
    build_sector(16'hFFFF);
    foreach (sec_q[i]) host_q.push_back(sec_q[i]);
    CD_SPD = 1'b1; AUDIO = 1'b0;
    repeat (30) @(posedge CLK);
    base = mon_q.size();
    #1 RUN = 1'b1;
    wait_words(base, 600, 6000, "rstmid");
    @(posedge CLK);
    #1 RST = 1'b1; RUN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    n_chk++; if (CD_D !== 16'h0000) $display("FAIL rstmid_cd_d: got %h required 0000", CD_D); else n_pass++;
    n_chk++; if (CD_CK !== 1'b0) $display("FAIL rstmid_cd_ck: got %b required 0", CD_CK); else n_pass++;
    n_chk++; if (SECTOR_DONE !== 1'b0) $display("FAIL rstmid_done: got %b required 0", SECTOR_DONE); else n_pass++;
    n_chk++; if (STATUS !== 3'b000) $display("FAIL rstmid_status: got %b required 000", STATUS); else n_pass++;
    n_chk++; if (UNDERRUN_CNT !== 8'h00) $display("FAIL rstmid_ucnt: got %h required 00", UNDERRUN_CNT); else n_pass++;
    n_chk++; if (HOST_READY !== 1'b0) $display("FAIL rstmid_ready: got %b required 0", HOST_READY); else n_pass++;
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    // Leftover non-SOF words of the aborted sector stay queued ahead of a new sector.
    build_sector(16'hFFFF);
    exp_q.delete();
    foreach (sec_q[i]) host_q.push_back(sec_q[i]);
    for (int i = 0; i < 30; i++) exp_q.push_back({1'b0, sec_q[i]});
    base = mon_q.size();
    #1 RUN = 1'b1;
    wait_words(base, 30, 4000, "rstmid");
    d = first_diff(base);
    n_chk++; if (d !== -1) $display("FAIL rstmid_realign: first bad index %0d", d); else n_pass++;
    do_reset();
  endtask

  initial begin
    RST = 1'b1; RUN = 1'b0; CD_SPD = 1'b1; AUDIO = 1'b0;
    test_reset();
    test_sector_speed(1'b1);
    test_sector_speed(1'b0);
    test_underrun();
    test_sync();
    test_align();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
